regfile_wb_scheduler: RTL and testbench

//  Owns the single write port of the integer register file and schedules it between NREQ write-back

---
 rtl/regfile_wb_scheduler_pkg.sv | 24 ++
 rtl/regfile_wb_scheduler_rr_arbiter.sv | 29 ++
 rtl/regfile_wb_scheduler.sv | 125 ++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants and small helpers for the register-file write-back scheduler.
// Default widths match the integer core: 64-bit x-registers, 32 of them, and three
// write-back requesters in fixed index order (ALU, load unit, mul/div).
package regfile_wb_scheduler_pkg;

  localparam int DEF_XLEN    = 64;
  localparam int DEF_REG_NUM = 32;
  localparam int DEF_NREQ    = 3;

  localparam int WB_ALU    = 0;
  localparam int WB_LOAD   = 1;
  localparam int WB_MULDIV = 2;

  // Width of a round-robin pointer able to name any of n requesters.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Next requester index after idx, wrapping from n-1 back to 0.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above ptr, wrapping
// around to index 0. Purely combinational; the pointer is owned by the caller.
module regfile_wb_scheduler_rr_arbiter
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int N = DEF_NREQ
) (
  input  logic [N-1:0]               req,
  input  logic [ptr_width(N)-1:0]    ptr,
  output logic [N-1:0]               gnt
);

  // Walk the requesters starting at ptr and grant the first one that is asking.
  always_comb begin
    int  idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Owns the register-file write port: round-robin arbitration among write-back
// requesters, a one-cycle registered write path, and a pending-write scoreboard
// that stalls issue on RAW/WAW hazards until the producing write has committed.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int REG_NUM = DEF_REG_NUM,
  parameter int NREQ    = DEF_NREQ
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst,
  input  logic                             flush,
  input  logic                             iss_valid,
  input  logic [$clog2(REG_NUM)-1:0]       iss_rs1,
  input  logic [$clog2(REG_NUM)-1:0]       iss_rs2,
  input  logic [$clog2(REG_NUM)-1:0]       iss_rd,
  input  logic                             iss_rs1_en,
  input  logic                             iss_rs2_en,
  input  logic                             iss_rd_en,
  output logic                             iss_stall,
  input  logic [NREQ-1:0]                  wb_valid,
  input  logic [NREQ*$clog2(REG_NUM)-1:0]  wb_addr,
  input  logic [NREQ*XLEN-1:0]             wb_data,
  output logic [NREQ-1:0]                  wb_ready,
  output logic                             rf_we,
  output logic [$clog2(REG_NUM)-1:0]       rf_waddr,
  output logic [XLEN-1:0]                  rf_wdata,
  output logic                             wb_err
);

  localparam int AW    = $clog2(REG_NUM);
  localparam int PTR_W = ptr_width(NREQ);

  logic [REG_NUM-1:0] busy, busy_next;
  logic [REG_NUM-1:0] stale, stale_next;
  logic [PTR_W-1:0]   rr_ptr;
  logic [NREQ-1:0]    gnt;
  logic [PTR_W-1:0]   win_idx;
  logic [AW-1:0]      win_addr;
  logic [XLEN-1:0]    win_data;
  logic               transfer;
  logic               accept;
  logic               err_hit;

  regfile_wb_scheduler_rr_arbiter #(.N(NREQ)) u_arb (
    .req (wb_valid),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  assign wb_ready = gnt;
  assign transfer = |gnt;

  // Pick out the winning requester's index, destination and data from the packed buses.
  always_comb begin
    win_idx  = '0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_idx  = PTR_W'(i);
        win_addr = wb_addr[AW*i +: AW];
        win_data = wb_data[XLEN*i +: XLEN];
      end
    end
  end

  // Hazard check uses only registered busy bits and issue inputs, never the write-back side.
  assign iss_stall = iss_valid & ((iss_rs1_en & busy[iss_rs1]) |
                                  (iss_rs2_en & busy[iss_rs2]) |
                                  (iss_rd_en  & busy[iss_rd]));
  assign accept    = iss_valid & ~iss_stall;

  // A write to an idle register is an error unless it is a leftover from a flushed producer.
  assign err_hit = transfer && (win_addr != '0) && !busy[win_addr] && !stale[win_addr] && !flush;

  // Next scoreboard: commit clears, new producer sets (and wins), flush wipes everything.
  always_comb begin
    busy_next = busy;
    if (rf_we) busy_next[rf_waddr] = 1'b0;
    if (accept && iss_rd_en && (iss_rd != '0)) busy_next[iss_rd] = 1'b1;
    if (flush) busy_next = '0;
    busy_next[0] = 1'b0;
  end

  // Remember registers whose producers were flushed so their late write-backs are not errors.
  always_comb begin
    stale_next = stale;
    if (flush) stale_next = stale | busy;
    if (transfer) stale_next[win_addr] = 1'b0;
    stale_next[0] = 1'b0;
  end

  // Scoreboard, flushed-producer tracking, pointer and sticky error state.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      busy   <= '0;
      stale  <= '0;
      rr_ptr <= '0;
      wb_err <= 1'b0;
    end else begin
      busy  <= busy_next;
      stale <= stale_next;
      if (transfer) rr_ptr <= PTR_W'(wrap_inc(int'(win_idx), NREQ));
      if (err_hit) wb_err <= 1'b1;
    end
  end

  // Registered write port; x0 transfers complete the handshake but never write.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= transfer && (win_addr != '0);
      if (transfer && (win_addr != '0)) begin
        rf_waddr <= win_addr;
        rf_wdata <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed vector table, hand-written
// corner-case sequences and randomized traffic, all checked against a behavioural model.
module tb_regfile_wb_scheduler;

  localparam int XLEN = 64;
  localparam int NREQ = 3;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          flush;
  logic          iss_valid;
  logic [4:0]    iss_rs1, iss_rs2, iss_rd;
  logic          iss_rs1_en, iss_rs2_en, iss_rd_en;
  logic          iss_stall;
  logic [2:0]    wb_valid;
  logic [14:0]   wb_addr;
  logic [191:0]  wb_data;
  logic [2:0]    wb_ready;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [63:0]   rf_wdata;
  logic          wb_err;

  regfile_wb_scheduler #(.XLEN(64), .REG_NUM(32), .NREQ(3)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .flush      (flush),
    .iss_valid  (iss_valid),
    .iss_rs1    (iss_rs1),
    .iss_rs2    (iss_rs2),
    .iss_rd     (iss_rd),
    .iss_rs1_en (iss_rs1_en),
    .iss_rs2_en (iss_rs2_en),
    .iss_rd_en  (iss_rd_en),
    .iss_stall  (iss_stall),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .wb_ready   (wb_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .wb_err     (wb_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit          valid;
    logic [4:0]  rs1, rs2, rd;
    bit          rs1_en, rs2_en, rd_en, fl;
    logic [2:0]  wbv;
    logic [14:0] wba;
    logic [63:0] wbd;
    bit          e_stall;
    logic [2:0]  e_ready;
    bit          e_we;
    logic [4:0]  e_waddr;
    logic [63:0] e_wdata;
    bit          e_err;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state: which registers await a write, flushed producers,
  // round-robin position, and what the write port should show after each edge.
  bit          mbusy[32];
  bit          mstale[32];
  int          mptr;
  bit          mwe;
  logic [4:0]  mwaddr;
  logic [63:0] mwdata;
  bit          merr;

  logic [2:0]  last_ready;
  logic        last_stall;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 32; k++) begin
      mbusy[k]  = 1'b0;
      mstale[k] = 1'b0;
    end
    mptr = 0; mwe = 0; mwaddr = '0; mwdata = '0; merr = 0;
  endtask

  function automatic int model_grant();
    for (int off = 0; off < NREQ; off++) begin
      if (wb_valid[(mptr + off) % NREQ]) return (mptr + off) % NREQ;
    end
    return -1;
  endfunction

  function automatic bit model_stall();
    return iss_valid && ((iss_rs1_en && mbusy[iss_rs1]) ||
                         (iss_rs2_en && mbusy[iss_rs2]) ||
                         (iss_rd_en  && mbusy[iss_rd]));
  endfunction

  task automatic model_update(input int g, input bit stall_exp);
    bit          xfer;
    logic [4:0]  a;
    bit          old_busy[32];
    xfer = (g >= 0);
    a    = xfer ? wb_addr[5*g +: 5] : 5'd0;
    old_busy = mbusy;
    if (xfer && a != 0 && !mbusy[a] && !mstale[a] && !flush) merr = 1;
    if (flush) for (int k = 0; k < 32; k++) mstale[k] = mstale[k] | old_busy[k];
    if (xfer) mstale[a] = 0;
    mstale[0] = 0;
    if (mwe) mbusy[mwaddr] = 0;
    if (iss_valid && !stall_exp && iss_rd_en && iss_rd != 0) mbusy[iss_rd] = 1;
    if (flush) for (int k = 0; k < 32; k++) mbusy[k] = 0;
    mwe = xfer && (a != 0);
    if (mwe) begin
      mwaddr = a;
      mwdata = wb_data[64*g +: 64];
    end
    if (xfer) mptr = (g + 1) % NREQ;
  endtask

  task automatic idle_inputs();
    flush = 0; iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
    iss_rs1_en = 0; iss_rs2_en = 0; iss_rd_en = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic next_cycle();
    @(negedge sys_clk);
    idle_inputs();
  endtask

  // One clock: compare combinational outputs before the edge, registered ones after.
  task automatic applyStimulus();
    int g;
    bit s;
    #1;
    g = model_grant();
    s = model_stall();
    last_ready = wb_ready;
    last_stall = iss_stall;
    checkOutput("iss_stall", {63'd0, iss_stall}, {63'd0, s});
    checkOutput("wb_ready", {61'd0, wb_ready}, (g < 0) ? 64'd0 : (64'd1 << g));
    @(posedge sys_clk);
    model_update(g, s);
    #1;
    checkOutput("rf_we", {63'd0, rf_we}, {63'd0, mwe});
    checkOutput("rf_waddr", {59'd0, rf_waddr}, {59'd0, mwaddr});
    checkOutput("rf_wdata", rf_wdata, mwdata);
    checkOutput("wb_err", {63'd0, wb_err}, {63'd0, merr});
  endtask

  task automatic do_reset();
    sys_rst  = 1;
    wb_valid = 3'b111;
    wb_addr  = {5'd3, 5'd2, 5'd1};
    iss_valid = 1; iss_rs1 = 5'd1; iss_rs1_en = 1;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    checkOutput("rst_rf_we", {63'd0, rf_we}, 64'd0);
    checkOutput("rst_wb_err", {63'd0, wb_err}, 64'd0);
    checkOutput("rst_stall", {63'd0, iss_stall}, 64'd0);
    @(negedge sys_clk);
    sys_rst = 0;
    idle_inputs();
  endtask

  vec_t vecs[10];

  initial begin
    logic [2:0] rr_exp[6];
    int q[$];

    vecs[0] = '{1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 15'd0, 64'h0,
                1'b0, 3'b000, 1'b0, 5'd0, 64'h0, 1'b0};
    vecs[1] = '{1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 15'd0, 64'h0,
                1'b1, 3'b000, 1'b0, 5'd0, 64'h0, 1'b0};
    vecs[2] = '{1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 15'd5, 64'hDEAD,
                1'b1, 3'b001, 1'b1, 5'd5, 64'hDEAD, 1'b0};
    vecs[3] = '{1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 15'd0, 64'h0,
                1'b1, 3'b000, 1'b0, 5'd5, 64'hDEAD, 1'b0};
    vecs[4] = '{1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 15'd0, 64'h0,
                1'b0, 3'b000, 1'b0, 5'd5, 64'hDEAD, 1'b0};
    vecs[5] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 15'd0, 64'h1234,
                1'b0, 3'b010, 1'b0, 5'd5, 64'hDEAD, 1'b0};
    vecs[6] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 15'h2400, 64'h99,
                1'b0, 3'b100, 1'b1, 5'd9, 64'h99, 1'b1};
    vecs[7] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 15'd0, 64'h0,
                1'b0, 3'b000, 1'b0, 5'd9, 64'h99, 1'b1};
    vecs[8] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 15'd0, 64'h77,
                1'b0, 3'b001, 1'b0, 5'd9, 64'h99, 1'b1};
    vecs[9] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 15'd0, 64'h77,
                1'b0, 3'b010, 1'b0, 5'd9, 64'h99, 1'b1};

    idle_inputs();
    sys_rst = 1;
    @(negedge sys_clk);
    do_reset();

    // Directed table: RAW stall through the commit cycle, x0 write, idle-register error.
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      iss_valid = vecs[i].valid; iss_rs1 = vecs[i].rs1; iss_rs2 = vecs[i].rs2; iss_rd = vecs[i].rd;
      iss_rs1_en = vecs[i].rs1_en; iss_rs2_en = vecs[i].rs2_en; iss_rd_en = vecs[i].rd_en;
      flush = vecs[i].fl; wb_valid = vecs[i].wbv; wb_addr = vecs[i].wba;
      wb_data = {3{vecs[i].wbd}};
      applyStimulus();
      checkOutput($sformatf("vec%0d_stall", i), {63'd0, last_stall}, {63'd0, vecs[i].e_stall});
      checkOutput($sformatf("vec%0d_ready", i), {61'd0, last_ready}, {61'd0, vecs[i].e_ready});
      checkOutput($sformatf("vec%0d_we", i), {63'd0, rf_we}, {63'd0, vecs[i].e_we});
      checkOutput($sformatf("vec%0d_waddr", i), {59'd0, rf_waddr}, {59'd0, vecs[i].e_waddr});
      checkOutput($sformatf("vec%0d_wdata", i), rf_wdata, vecs[i].e_wdata);
      checkOutput($sformatf("vec%0d_err", i), {63'd0, wb_err}, {63'd0, vecs[i].e_err});
    end

    // Round robin: x1..x3 busy, all requesters valid every cycle.
    @(negedge sys_clk);
    do_reset();
    for (int r = 1; r <= 3; r++) begin
      next_cycle();
      iss_valid = 1; iss_rd = 5'(r); iss_rd_en = 1;
      applyStimulus();
    end
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      wb_valid = 3'b111;
      wb_addr  = {5'd3, 5'd2, 5'd1};
      wb_data  = {64'(c + 300), 64'(c + 200), 64'(c + 100)};
      applyStimulus();
      checkOutput($sformatf("rr_grant%0d", c), {61'd0, last_ready}, {61'd0, rr_exp[c]});
    end

    // Same-edge clear and set of x7: set must win.
    @(negedge sys_clk);
    do_reset();
    next_cycle();
    wb_valid = 3'b001; wb_addr = 15'd7; wb_data = {3{64'h7777}};
    applyStimulus();
    next_cycle();
    iss_valid = 1; iss_rd = 5'd7; iss_rd_en = 1;
    applyStimulus();
    checkOutput("simul_accept", {63'd0, last_stall}, 64'd0);
    checkOutput("simul_we", {63'd0, rf_we}, 64'd0);
    next_cycle();
    iss_valid = 1; iss_rs1 = 5'd7; iss_rs1_en = 1;
    applyStimulus();
    checkOutput("simul_rs1_stall", {63'd0, last_stall}, 64'd1);

    // Flush: x3/x4 busy, flush ignores a same-cycle set, late x3 write is not an error.
    @(negedge sys_clk);
    do_reset();
    for (int r = 3; r <= 4; r++) begin
      next_cycle();
      iss_valid = 1; iss_rd = 5'(r); iss_rd_en = 1;
      applyStimulus();
    end
    next_cycle();
    flush = 1; iss_valid = 1; iss_rd = 5'd6; iss_rd_en = 1;
    applyStimulus();
    next_cycle();
    iss_valid = 1; iss_rs1 = 5'd3; iss_rs1_en = 1; iss_rs2 = 5'd4; iss_rs2_en = 1;
    applyStimulus();
    checkOutput("flush_no_stall", {63'd0, last_stall}, 64'd0);
    next_cycle();
    iss_valid = 1; iss_rs1 = 5'd6; iss_rs1_en = 1;
    applyStimulus();
    checkOutput("flush_set_ignored", {63'd0, last_stall}, 64'd0);
    next_cycle();
    wb_valid = 3'b010; wb_addr = {5'd0, 5'd3, 5'd0}; wb_data = {3{64'h3333}};
    applyStimulus();
    checkOutput("flush_late_we", {63'd0, rf_we}, 64'd1);
    checkOutput("flush_late_err", {63'd0, wb_err}, 64'd0);

    // Randomized traffic with a reset dropped into the middle of a committing write.
    @(negedge sys_clk);
    do_reset();
    for (int c = 0; c < 400; c++) begin
      next_cycle();
      iss_valid  = 1'($urandom_range(0, 1));
      iss_rs1    = 5'($urandom_range(0, 7));
      iss_rs2    = 5'($urandom_range(0, 7));
      iss_rd     = 5'($urandom_range(0, 7));
      iss_rs1_en = 1'($urandom_range(0, 1));
      iss_rs2_en = 1'($urandom_range(0, 1));
      iss_rd_en  = 1'($urandom_range(0, 1));
      flush      = ($urandom_range(0, 15) == 0);
      wb_valid   = 3'($urandom_range(0, 7));
      q.delete();
      for (int k = 1; k < 8; k++) if (mbusy[k]) q.push_back(k);
      for (int i = 0; i < NREQ; i++) begin
        if (q.size() > 0 && $urandom_range(0, 3) != 0)
          wb_addr[5*i +: 5] = 5'(q[$urandom_range(0, q.size() - 1)]);
        else
          wb_addr[5*i +: 5] = 5'($urandom_range(0, 7));
      end
      wb_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      applyStimulus();
      if (c == 200) begin
        next_cycle();
        wb_valid = 3'b001; wb_addr = 15'd3; wb_data = {3{64'hABCD}};
        applyStimulus();
        #2;
        sys_rst = 1;
        #1;
        checkOutput("midrst_rf_we", {63'd0, rf_we}, 64'd0);
        checkOutput("midrst_wdata", rf_wdata, 64'd0);
        do_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
